// File: rtl/speicher_arbiter.sv
// Round-robin arbiter that lets KANAELE requesting ports share one memory port.
// Only one access is in flight at a time; every output comes straight from a flop.
module speicher_arbiter #(
    parameter int KANAELE      = 2,
    parameter int ADRESSBREITE = 32,
    parameter int DATENBREITE  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [KANAELE*ADRESSBREITE-1:0] Adresse,
    input  logic [KANAELE*DATENBREITE-1:0]  DatenRaus,
    input  logic [KANAELE-1:0]              LeseDaten,
    input  logic [KANAELE-1:0]              SchreibeDaten,
    output logic [DATENBREITE-1:0]          DatenRein,
    output logic [KANAELE-1:0]              DatenGeladen,
    output logic [KANAELE-1:0]              DatenGespeichert,
    output logic [ADRESSBREITE-1:0]         SpeicherAdresse,
    output logic [DATENBREITE-1:0]          SpeicherSchreibDaten,
    output logic                            SpeicherLesen,
    output logic                            SpeicherSchreiben,
    input  logic [DATENBREITE-1:0]          SpeicherLeseDaten,
    input  logic                            SpeicherFertig,
    output logic [2:0]                      AktiverKanal,
    output logic                            Belegt
);

    typedef enum logic [1:0] {FREI, ZUGRIFF, ANTWORT} zustand_t;

    zustand_t                zustand, zustand_n;
    logic [2:0]              letzter, letzter_n;
    logic [2:0]              kanal_n;
    logic [ADRESSBREITE-1:0] adresse_n;
    logic [DATENBREITE-1:0]  schreibdaten_n;
    logic [DATENBREITE-1:0]  rein_n;
    logic                    lesen_n, schreiben_n, belegt_n;
    logic [KANAELE-1:0]      geladen_n, gespeichert_n;

    logic [KANAELE-1:0]      anfrage;
    logic                    gefunden;
    logic [2:0]              wahl;
    logic [ADRESSBREITE-1:0] adresse_wahl;
    logic [DATENBREITE-1:0]  daten_wahl;
    logic                    schreib_wahl;

    assign anfrage = LeseDaten | SchreibeDaten;

    // Round-robin search: the port after the last grant has highest priority.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        gefunden     = 1'b0;
        wahl         = '0;
        adresse_wahl = '0;
        daten_wahl   = '0;
        schreib_wahl = 1'b0;
        for (int i = 0; i < KANAELE; i++) begin
            for (int k = 0; k < KANAELE; k++) begin
                if (!gefunden && anfrage[k] && k == (int'(letzter) + 1 + i) % KANAELE) begin
                    gefunden = 1'b1;
                    wahl     = 3'(k);
                end
            end
        end
        for (int k = 0; k < KANAELE; k++) begin
            if (3'(k) == wahl) begin
                adresse_wahl = Adresse[k*ADRESSBREITE +: ADRESSBREITE];
                daten_wahl   = DatenRaus[k*DATENBREITE +: DATENBREITE];
                schreib_wahl = SchreibeDaten[k];
            end
        end
    end

    always_comb begin
        zustand_n      = zustand;
        letzter_n      = letzter;
        kanal_n        = AktiverKanal;
        adresse_n      = SpeicherAdresse;
        schreibdaten_n = SpeicherSchreibDaten;
        rein_n         = DatenRein;
        lesen_n        = SpeicherLesen;
        schreiben_n    = SpeicherSchreiben;
        belegt_n       = Belegt;
        geladen_n      = '0;
        gespeichert_n  = '0;

        case (zustand)
            FREI: begin
                if (gefunden) begin
                    zustand_n      = ZUGRIFF;
                    letzter_n      = wahl;
                    kanal_n        = wahl;
                    adresse_n      = adresse_wahl;
                    schreibdaten_n = daten_wahl;
                    // A write wins when both request bits are set.
                    schreiben_n    = schreib_wahl;
                    lesen_n        = !schreib_wahl;
                    belegt_n       = 1'b1;
                end
            end
            ZUGRIFF: begin
                if (SpeicherFertig) begin
                    zustand_n   = ANTWORT;
                    lesen_n     = 1'b0;
                    schreiben_n = 1'b0;
                    if (!SpeicherSchreiben) begin
                        rein_n = SpeicherLeseDaten;
                    end
                    for (int k = 0; k < KANAELE; k++) begin
                        if (3'(k) == AktiverKanal) begin
                            geladen_n[k]     = !SpeicherSchreiben;
                            gespeichert_n[k] = SpeicherSchreiben;
                        end
                    end
                end
            end
            ANTWORT: begin
                zustand_n = FREI;
                belegt_n  = 1'b0;
            end
            default: begin
                zustand_n = FREI;
                belegt_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zustand              <= FREI;
            letzter              <= 3'(KANAELE - 1);
            AktiverKanal         <= '0;
            SpeicherAdresse      <= '0;
            SpeicherSchreibDaten <= '0;
            DatenRein            <= '0;
            SpeicherLesen        <= 1'b0;
            SpeicherSchreiben    <= 1'b0;
            Belegt               <= 1'b0;
            DatenGeladen         <= '0;
            DatenGespeichert     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            zustand              <= zustand_n;
            letzter              <= letzter_n;
            AktiverKanal         <= kanal_n;
            SpeicherAdresse      <= adresse_n;
            SpeicherSchreibDaten <= schreibdaten_n;
            DatenRein            <= rein_n;
            SpeicherLesen        <= lesen_n;
            SpeicherSchreiben    <= schreiben_n;
            Belegt               <= belegt_n;
            DatenGeladen         <= geladen_n;
            DatenGespeichert     <= gespeichert_n;
        end
    end

endmodule

// File: tb/tb_speicher_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level model
// of the two-port arbiter; inputs change and outputs are sampled on the falling edge.
module tb_speicher_arbiter;

    localparam int K = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   Adresse, DatenRaus;
    logic [1:0]    LeseDaten, SchreibeDaten;
    logic [31:0]   DatenRein;
    logic [1:0]    DatenGeladen, DatenGespeichert;
    logic [31:0]   SpeicherAdresse, SpeicherSchreibDaten;
    logic          SpeicherLesen, SpeicherSchreiben;
    logic [31:0]   SpeicherLeseDaten;
    logic          SpeicherFertig;
    logic [2:0]    AktiverKanal;
    logic          Belegt;

    int total = 0;
    int bad   = 0;

    speicher_arbiter #(.KANAELE(K), .ADRESSBREITE(32), .DATENBREITE(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .Adresse             (Adresse),
        .DatenRaus           (DatenRaus),
        .LeseDaten           (LeseDaten),
        .SchreibeDaten       (SchreibeDaten),
        .DatenRein           (DatenRein),
        .DatenGeladen        (DatenGeladen),
        .DatenGespeichert    (DatenGespeichert),
        .SpeicherAdresse     (SpeicherAdresse),
        .SpeicherSchreibDaten(SpeicherSchreibDaten),
        .SpeicherLesen       (SpeicherLesen),
        .SpeicherSchreiben   (SpeicherSchreiben),
        .SpeicherLeseDaten   (SpeicherLeseDaten),
        .SpeicherFertig      (SpeicherFertig),
        .AktiverKanal        (AktiverKanal),
        .Belegt              (Belegt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory side of one access: hold Fertig low for 'waits' strobe cycles, then complete.
    task automatic serve(input int waits, input logic [31:0] rdv, output int n);
        logic [31:0] a0, d0;
        bit done;
        a0 = SpeicherAdresse;
        d0 = SpeicherSchreibDaten;
        n = 0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (!(SpeicherLesen || SpeicherSchreiben)) begin
                done = 1;
            end else begin
                n++;
                if (n > 1) begin
                    check("hold_addr", SpeicherAdresse, a0);
                    check("hold_wdata", SpeicherSchreibDaten, d0);
                end
                SpeicherFertig    = (n > waits);
                SpeicherLeseDaten = rdv;
                @(negedge clk);
            end
        end
        SpeicherFertig = 1'b0;
        check("serve_done", done, 1);
    endtask

    task automatic wait_strobe();
        bit ok = 0;
        for (int c = 0; c < 6 && !ok; c++) begin
            @(negedge clk);
            ok = SpeicherLesen || SpeicherSchreiben;
        end
        check("wait_strobe", ok, 1);
    endtask

    function automatic int rr(input int last, input logic [K-1:0] req);
        for (int i = 1; i <= K; i++) begin
            if (req[(last + i) % K]) return (last + i) % K;
        end
        return -1;
    endfunction

    // Randomized-phase state
    logic [1:0]  rl, rs, prev_rl, prev_rs;
    logic [31:0] ra[K], rdd[K], prev_ra[K], prev_rdd[K];
    logic        prev_fertig;
    logic [31:0] prev_mem, exp_rdata, ga, gd, last_rd;
    logic        gw;
    int          m, last, gk, waited, n, op;
    bit          awaiting[K];

    initial begin
        rst_n = 1'b0;
        Adresse = '0; DatenRaus = '0; LeseDaten = '0; SchreibeDaten = '0;
        SpeicherLeseDaten = '0; SpeicherFertig = 1'b0;

        #12;
        check("rst_belegt", Belegt, 0);
        check("rst_strobes", {SpeicherLesen, SpeicherSchreiben}, 2'b00);
        check("rst_pulses", {DatenGeladen, DatenGespeichert}, 4'b0000);
        check("rst_kanal", AktiverKanal, 0);
        check("rst_rdata", DatenRein, 0);
        check("rst_addr", SpeicherAdresse, 0);
        check("rst_wdata", SpeicherSchreibDaten, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read with two wait cycles
        @(negedge clk);
        Adresse[31:0] = 32'h100;
        LeseDaten = 2'b01;
        @(negedge clk);
        check("rd_belegt", Belegt, 1);
        check("rd_strobes", {SpeicherLesen, SpeicherSchreiben}, 2'b10);
        check("rd_kanal", AktiverKanal, 0);
        check("rd_addr", SpeicherAdresse, 32'h100);
        serve(2, 32'hDEADBEEF, n);
        check("rd_strobe_cycles", n, 3);
        check("rd_geladen", DatenGeladen, 2'b01);
        check("rd_gespeichert", DatenGespeichert, 2'b00);
        check("rd_data", DatenRein, 32'hDEADBEEF);
        LeseDaten = 2'b00;
        @(negedge clk);
        check("rd_pulse_once", DatenGeladen, 2'b00);
        check("rd_free", Belegt, 0);

        // Both ports requesting continuously from reset
        rst_n = 1'b0;
        LeseDaten = 2'b11;
        Adresse = {32'h204, 32'h200};
        @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_strobe();
            check("rr_kanal", AktiverKanal, g % 2);
            check("rr_addr", SpeicherAdresse, (g % 2) ? 32'h204 : 32'h200);
            last_rd = 32'hC0DE0000 + 32'(g);
            serve(0, last_rd, n);
            check("rr_geladen", DatenGeladen, 2'b01 << (g % 2));
            check("rr_data", DatenRein, last_rd);
        end
        LeseDaten = 2'b00;

        // Port 1 write; its inputs change after grant
        Adresse[63:32] = 32'h40;
        DatenRaus[63:32] = 32'h12345678;
        SchreibeDaten = 2'b10;
        wait_strobe();
        check("wr_kanal", AktiverKanal, 1);
        check("wr_strobes", {SpeicherLesen, SpeicherSchreiben}, 2'b01);
        check("wr_addr", SpeicherAdresse, 32'h40);
        check("wr_wdata", SpeicherSchreibDaten, 32'h12345678);
        Adresse[63:32] = 32'hFFF0;
        DatenRaus[63:32] = 32'h0BADF00D;
        serve(1, 32'h55555555, n);
        check("wr_gespeichert", DatenGespeichert, 2'b10);
        check("wr_geladen", DatenGeladen, 2'b00);
        check("wr_rdata_kept", DatenRein, last_rd);
        SchreibeDaten = 2'b00;

        // Both bits on port 0, request withdrawn during the access
        Adresse[31:0] = 32'h80;
        DatenRaus[31:0] = 32'hA5A5A5A5;
        LeseDaten = 2'b01;
        SchreibeDaten = 2'b01;
        wait_strobe();
        check("both_kanal", AktiverKanal, 0);
        check("both_strobes", {SpeicherLesen, SpeicherSchreiben}, 2'b01);
        check("both_wdata", SpeicherSchreibDaten, 32'hA5A5A5A5);
        LeseDaten = 2'b00;
        SchreibeDaten = 2'b00;
        serve(1, 32'h66666666, n);
        check("both_gespeichert", DatenGespeichert, 2'b01);
        check("both_geladen", DatenGeladen, 2'b00);
        check("both_rdata_kept", DatenRein, last_rd);

        // Stray completion while idle
        @(negedge clk);
        SpeicherFertig = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_fertig", {Belegt, SpeicherLesen, SpeicherSchreiben, DatenGeladen, DatenGespeichert}, 7'b0);
        end
        SpeicherFertig = 1'b0;

        // Reset in the middle of an access
        Adresse[63:32] = 32'h300;
        LeseDaten = 2'b10;
        wait_strobe();
        check("mid_kanal", AktiverKanal, 1);
        LeseDaten = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", {SpeicherLesen, SpeicherSchreiben}, 2'b00);
        check("mid_rst_belegt", Belegt, 0);
        check("mid_rst_addr", SpeicherAdresse, 0);
        SpeicherFertig = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_pulses", {DatenGeladen, DatenGespeichert}, 4'b0000);
        end
        SpeicherFertig = 1'b0;
        rst_n = 1'b1;
        wait_strobe();
        check("post_rst_kanal", AktiverKanal, 0);
        serve(0, 32'h11112222, n);
        check("post_rst_geladen", DatenGeladen, 2'b01);
        LeseDaten = 2'b10;
        wait_strobe();
        check("post_rst_next", AktiverKanal, 1);
        serve(0, 32'h33334444, n);
        check("post_rst_geladen1", DatenGeladen, 2'b10);
        LeseDaten = 2'b00;

        // Randomized run against the transaction model
        @(negedge clk);
        rst_n = 1'b0;
        rl = '0; rs = '0; prev_rl = '0; prev_rs = '0;
        for (int p = 0; p < K; p++) begin
            ra[p] = '0; rdd[p] = '0; prev_ra[p] = '0; prev_rdd[p] = '0; awaiting[p] = 0;
        end
        LeseDaten = '0; SchreibeDaten = '0; SpeicherFertig = 1'b0;
        prev_fertig = 1'b0; prev_mem = '0;
        m = 0; last = K - 1; gk = 0; gw = 1'b0; ga = '0; gd = '0; exp_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            case (m)
                0: if ((prev_rl | prev_rs) != 0) begin
                    gk = rr(last, prev_rl | prev_rs);
                    last = gk;
                    gw = prev_rs[gk];
                    ga = prev_ra[gk];
                    gd = prev_rdd[gk];
                    awaiting[gk] = 1;
                    waited = 0;
                    m = 1;
                end
                1: if (prev_fertig) begin
                    if (!gw) exp_rdata = prev_mem;
                    m = 2;
                end
                default: m = 0;
            endcase

            check("r_belegt", Belegt, m != 0);
            check("r_strobes", {SpeicherLesen, SpeicherSchreiben}, {m == 1 && !gw, m == 1 && gw});
            check("r_geladen", DatenGeladen, (m == 2 && !gw) ? (2'b01 << gk) : 2'b00);
            check("r_gespeichert", DatenGespeichert, (m == 2 && gw) ? (2'b01 << gk) : 2'b00);
            check("r_rdata", DatenRein, exp_rdata);
            if (m != 0) begin
                check("r_kanal", AktiverKanal, gk);
                check("r_addr", SpeicherAdresse, ga);
                check("r_wdata", SpeicherSchreibDaten, gd);
            end

            if (m == 1) begin
                waited++;
                SpeicherFertig = (waited > 3) || ($urandom_range(0, 2) == 0);
            end else begin
                SpeicherFertig = ($urandom_range(0, 3) == 0);
            end
            SpeicherLeseDaten = $urandom;

            for (int p = 0; p < K; p++) begin
                if (m == 2 && gk == p) begin
                    rl[p] = 1'b0; rs[p] = 1'b0; awaiting[p] = 0;
                end else if (m == 1 && gk == p) begin
                    ra[p] = $urandom; rdd[p] = $urandom;
                    if ($urandom_range(0, 7) == 0) begin
                        rl[p] = 1'b0; rs[p] = 1'b0;
                    end
                end else if (!awaiting[p] && !(rl[p] | rs[p]) && $urandom_range(0, 2) == 0) begin
                    op = $urandom_range(0, 2);
                    rl[p] = (op != 1);
                    rs[p] = (op != 0);
                    ra[p] = $urandom;
                    rdd[p] = $urandom;
                end
            end
            LeseDaten = rl;
            SchreibeDaten = rs;
            Adresse = {ra[1], ra[0]};
            DatenRaus = {rdd[1], rdd[0]};
            prev_rl = rl; prev_rs = rs;
            for (int p = 0; p < K; p++) begin
                prev_ra[p] = ra[p]; prev_rdd[p] = rdd[p];
            end
            prev_fertig = SpeicherFertig;
            prev_mem = SpeicherLeseDaten;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
